// File: rtl/mem_pkg.sv
// Shared types for the fetch/data memory arbiter.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    SEL_IF = 1'b0,
    SEL_D  = 1'b1
  } sel_t;

  // Wide enough for latency counts up to 4 and burst counts up to 15.
  localparam int LAT_W   = 3;
  localparam int BURST_W = 4;

endpackage

// File: rtl/mem_arbiter_arb_prio.sv
// Data-over-fetch priority with a burst counter that forces a fetch grant
// after MAX_DBURST back-to-back data grants while fetch is waiting.
module arb_prio import mem_pkg::*; #(
  parameter int MAX_DBURST = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic if_req,
  input  logic d_req,
  output logic gnt_if,
  output logic gnt_d
);

  logic [BURST_W-1:0] burst_cnt;
  logic               fetch_turn;

  assign fetch_turn = if_req && (burst_cnt == BURST_W'(MAX_DBURST));
  assign gnt_d      = en && d_req && !fetch_turn;
  assign gnt_if     = en && if_req && !gnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      burst_cnt <= '0;
    end else if (gnt_if) begin
      burst_cnt <= '0;
    end else if (en && !if_req) begin
      burst_cnt <= '0;
    end else if (gnt_d && if_req && (burst_cnt != BURST_W'(MAX_DBURST))) begin
      burst_cnt <= burst_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store,
// one access outstanding at a time.
//
// state | meaning
// IDLE  | memory free; grant issued combinationally with the mem_en strobe
// WAIT  | access outstanding, counting MEM_LAT cycles
// DONE  | winner's valid pulses, read data visible
module mem_arbiter import mem_pkg::*; #(
  parameter int MEM_LAT    = 1,
  parameter int MAX_DBURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        stall
);

  state_t           state;
  logic [LAT_W-1:0] lat_cnt;
  sel_t             sel_q;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic             arb_en;
  logic             gnt_if;
  logic             gnt_d;

  assign arb_en = (state == IDLE) && !reset;

  arb_prio #(.MAX_DBURST(MAX_DBURST)) u_arb_prio (
    .clk    (clk),
    .reset  (reset),
    .en     (arb_en),
    .if_req (if_req),
    .d_req  (d_req),
    .gnt_if (gnt_if),
    .gnt_d  (gnt_d)
  );

  // Bus is driven straight from the winner on the grant cycle, then from the held copy.
  assign if_ready  = gnt_if;
  assign d_ready   = gnt_d;
  assign mem_en    = gnt_if || gnt_d;
  assign mem_we    = gnt_d && d_we;
  assign mem_addr  = gnt_d ? d_addr : (gnt_if ? if_addr : addr_q);
  assign mem_wdata = mem_en ? d_wdata : wdata_q;

  assign stall = !reset && ((if_req && !if_valid) || (d_req && !d_valid));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      lat_cnt  <= '0;
      sel_q    <= SEL_IF;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_if || gnt_d) begin
            state   <= WAIT;
            lat_cnt <= '0;
            sel_q   <= gnt_d ? SEL_D : SEL_IF;
            we_q    <= gnt_d && d_we;
            addr_q  <= gnt_d ? d_addr : if_addr;
            wdata_q <= d_wdata;
          end
        end
        WAIT: begin
          // mem_rdata is valid in the last WAIT cycle; capture so it lines up with valid.
          if (lat_cnt == LAT_W'(MEM_LAT - 1)) begin
            state <= DONE;
            if (sel_q == SEL_D) begin
              d_valid <= 1'b1;
              if (!we_q) d_rdata <= mem_rdata;
            end else begin
              if_valid <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
